// File: rtl/ram_arb_bridge_pkg.sv
// Shared definitions for the RAM arbitration bridge: FSM states, access-size
// encoding, grant identifiers, the default RAM base address and lane helpers.
package ram_arb_bridge_pkg;

  localparam logic [63:0] PC_START          = 64'h0000_0000_8000_0000;
  localparam logic [63:0] BASE_ADDR_DEFAULT = PC_START;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SIZE_B = 3'd0,
    SIZE_H = 3'd1,
    SIZE_W = 3'd2,
    SIZE_D = 3'd3
  } size_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_LS = 1'b1
  } grant_e;

  // One bit per byte lane touched by an access of 2^size bytes at offset off.
  function automatic logic [7:0] byte_mask(input logic [2:0] off, input logic [2:0] size);
    logic [15:0] base_m;
    logic [15:0] shifted_m;
    case (size)
      SIZE_B:  base_m = 16'h0001;
      SIZE_H:  base_m = 16'h0003;
      SIZE_W:  base_m = 16'h000F;
      SIZE_D:  base_m = 16'h00FF;
      default: base_m = 16'h0000;
    endcase
    shifted_m = base_m << off;
    return shifted_m[7:0];
  endfunction

  // True when the access is a legal size and stays inside one 64-bit word.
  function automatic logic size_fits(input logic [2:0] off, input logic [2:0] size);
    logic [3:0] end_byte;
    if (size > SIZE_D) begin
      return 1'b0;
    end else begin
      end_byte = {1'b0, off} + (4'd1 << size[1:0]);
      return (end_byte <= 4'd8);
    end
  endfunction

endpackage

// File: rtl/ram_arb_bridge_if.sv
// Bundle of the fetch port, load/store port and RAM port seen by the bridge.
interface ram_arb_bridge_if #(
  parameter int unsigned IDX_W = 16
);
  logic              if_req_i;
  logic [63:0]       if_addr_i;
  logic              if_ready_o;
  logic [31:0]       if_rdata_o;
  logic              ls_req_i;
  logic              ls_wen_i;
  logic [63:0]       ls_addr_i;
  logic [63:0]       ls_wdata_i;
  logic [2:0]        ls_size_i;
  logic              ls_ready_o;
  logic [63:0]       ls_rdata_o;
  logic              ls_err_o;
  logic              ram_en_o;
  logic [IDX_W-1:0]  ram_idx_o;
  logic              ram_wen_o;
  logic [63:0]       ram_wdata_o;
  logic [63:0]       ram_wmask_o;
  logic [63:0]       ram_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, ls_req_i, ls_wen_i, ls_addr_i, ls_wdata_i, ls_size_i, ram_rdata_i,
    output if_ready_o, if_rdata_o, ls_ready_o, ls_rdata_o, ls_err_o,
           ram_en_o, ram_idx_o, ram_wen_o, ram_wdata_o, ram_wmask_o
  );

  modport master (
    output if_req_i, if_addr_i, ls_req_i, ls_wen_i, ls_addr_i, ls_wdata_i, ls_size_i, ram_rdata_i,
    input  if_ready_o, if_rdata_o, ls_ready_o, ls_rdata_o, ls_err_o,
           ram_en_o, ram_idx_o, ram_wen_o, ram_wdata_o, ram_wmask_o
  );
endinterface

// File: rtl/ram_arb_bridge_lane_align.sv
// Byte-lane alignment between LSB-aligned core data and 64-bit RAM words.
module ram_lane_align
  import ram_arb_bridge_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [2:0]  size,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [63:0] wdata_sh,
  output logic [63:0] wmask,
  output logic [63:0] rdata_sh
);
  logic [7:0] bmask_s;
  logic [5:0] shamt_s;

  assign shamt_s = {off, 3'b000};

  // Shift data into/out of its lanes and expand the byte mask to bits.
  always_comb begin
    bmask_s  = byte_mask(off, size);
    wdata_sh = wdata << shamt_s;
    rdata_sh = rdata >> shamt_s;
    wmask    = 64'd0;
    for (int i = 0; i < 8; i++) begin
      wmask[i*8 +: 8] = {8{bmask_s[i]}};
    end
  end

endmodule

// File: rtl/ram_arb_bridge.sv
// Round-robin bridge from an instruction-fetch port and a load/store port onto
// a single-ported 64-bit RAM; one access in flight, response two cycles later.
module ram_arb_bridge
  import ram_arb_bridge_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int unsigned IDX_W     = 16
) (
  input logic             clock,
  input logic             reset,
  ram_arb_bridge_if.slave bus
);
  localparam logic [63:0] SPAN_BYTES = 64'd1 << (IDX_W + 3);

  state_e      state_r, state_nx_s;
  grant_e      last_grant_r, grant_r, grant_s;
  logic        take_s;
  logic        ls_err_s;
  logic [63:0] ls_diff_s, sel_addr_s, sel_diff_s;
  logic [2:0]  off_r, size_r, align_off_s, align_size_s;
  logic        word_sel_r, err_r;
  logic [63:0] wdata_sh_s, wmask_s, rdata_sh_s;

  logic             ram_en_r, ram_wen_r;
  logic [IDX_W-1:0] ram_idx_r;
  logic [63:0]      ram_wdata_r, ram_wmask_r;
  logic             if_ready_r, ls_ready_r, ls_err_r;
  logic [31:0]      if_rdata_r;
  logic [63:0]      ls_rdata_r;

  // Arbitration and next-state selection.
  always_comb begin
    state_nx_s = state_r;
    grant_s    = GRANT_IF;
    take_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.if_req_i && bus.ls_req_i) begin
          take_s     = 1'b1;
          grant_s    = (last_grant_r == GRANT_LS) ? GRANT_IF : GRANT_LS;
          state_nx_s = ST_ACCESS;
        end else if (bus.if_req_i) begin
          take_s     = 1'b1;
          grant_s    = GRANT_IF;
          state_nx_s = ST_ACCESS;
        end else if (bus.ls_req_i) begin
          take_s     = 1'b1;
          grant_s    = GRANT_LS;
          state_nx_s = ST_ACCESS;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_nx_s = ST_RESP;
      ST_RESP:   state_nx_s = ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // Address decode and load/store legality for the incoming request.
  always_comb begin
    ls_diff_s = bus.ls_addr_i - BASE_ADDR;
    ls_err_s  = !size_fits(bus.ls_addr_i[2:0], bus.ls_size_i)
             || (bus.ls_addr_i < BASE_ADDR)
             || (ls_diff_s >= SPAN_BYTES);
    if (grant_s == GRANT_IF) begin
      sel_addr_s = bus.if_addr_i;
    end else begin
      sel_addr_s = bus.ls_addr_i;
    end
    sel_diff_s = sel_addr_s - BASE_ADDR;
  end

  // Aligner sees live inputs while accepting, latched fields afterwards.
  always_comb begin
    if (state_r == ST_IDLE) begin
      align_off_s  = bus.ls_addr_i[2:0];
      align_size_s = bus.ls_size_i;
    end else begin
      align_off_s  = off_r;
      align_size_s = size_r;
    end
  end

  ram_lane_align u_align (
    .off      (align_off_s),
    .size     (align_size_s),
    .wdata    (bus.ls_wdata_i),
    .rdata    (bus.ram_rdata_i),
    .wdata_sh (wdata_sh_s),
    .wmask    (wmask_s),
    .rdata_sh (rdata_sh_s)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Request latch, RAM drive and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_r <= GRANT_LS;
      grant_r      <= GRANT_IF;
      off_r        <= 3'd0;
      size_r       <= 3'd0;
      word_sel_r   <= 1'b0;
      err_r        <= 1'b0;
      ram_en_r     <= 1'b0;
      ram_wen_r    <= 1'b0;
      ram_idx_r    <= '0;
      ram_wdata_r  <= 64'd0;
      ram_wmask_r  <= 64'd0;
      if_ready_r   <= 1'b0;
      if_rdata_r   <= 32'd0;
      ls_ready_r   <= 1'b0;
      ls_rdata_r   <= 64'd0;
      ls_err_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            grant_r      <= grant_s;
            last_grant_r <= grant_s;
            off_r        <= bus.ls_addr_i[2:0];
            size_r       <= bus.ls_size_i;
            word_sel_r   <= bus.if_addr_i[2];
            err_r        <= (grant_s == GRANT_LS) && ls_err_s;
            ram_en_r     <= !((grant_s == GRANT_LS) && ls_err_s);
            ram_wen_r    <= (grant_s == GRANT_LS) && bus.ls_wen_i && !ls_err_s;
            ram_idx_r    <= IDX_W'(sel_diff_s >> 3);
            if ((grant_s == GRANT_LS) && bus.ls_wen_i && !ls_err_s) begin
              ram_wdata_r <= wdata_sh_s;
              ram_wmask_r <= wmask_s;
            end else begin
              ram_wdata_r <= 64'd0;
              ram_wmask_r <= 64'd0;
            end
          end
        end
        ST_ACCESS: begin
          ram_en_r    <= 1'b0;
          ram_wen_r   <= 1'b0;
          ram_wdata_r <= 64'd0;
          ram_wmask_r <= 64'd0;
          if (grant_r == GRANT_IF) begin
            if_ready_r <= 1'b1;
            if_rdata_r <= word_sel_r ? bus.ram_rdata_i[63:32] : bus.ram_rdata_i[31:0];
          end else begin
            ls_ready_r <= 1'b1;
            ls_err_r   <= err_r;
            ls_rdata_r <= err_r ? 64'd0 : rdata_sh_s;
          end
        end
        ST_RESP: begin
          if_ready_r <= 1'b0;
          ls_ready_r <= 1'b0;
        end
        default: begin
          if_ready_r <= 1'b0;
          ls_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Reset arriving mid-access must not let the RAM see this cycle's strobe.
  assign bus.ram_en_o    = ram_en_r & ~reset;
  assign bus.ram_wen_o   = ram_wen_r & ~reset;
  assign bus.ram_idx_o   = ram_idx_r;
  assign bus.ram_wdata_o = ram_wdata_r;
  assign bus.ram_wmask_o = ram_wmask_r;
  assign bus.if_ready_o  = if_ready_r;
  assign bus.if_rdata_o  = if_rdata_r;
  assign bus.ls_ready_o  = ls_ready_r;
  assign bus.ls_rdata_o  = ls_rdata_r;
  assign bus.ls_err_o    = ls_err_r;

endmodule

// File: tb/tb_ram_arb_bridge.sv
// Self-checking bench for ram_arb_bridge: directed vector table, hand-written
// arbitration/reset sequences and randomized traffic against a byte-level RAM model.
module tb_ram_arb_bridge;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic        en;
    logic        wen;
    logic [15:0] idx;
    logic [63:0] wdata;
    logic [63:0] wmask;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  typedef struct packed {
    logic        is_ls;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  size;
    exp_t        e;
  } vec_t;

  logic clock;
  logic reset;
  logic [63:0] mem     [65536];
  logic [63:0] ref_mem [65536];
  int pass_cnt;
  int total_cnt;
  logic [31:0] last_if_rdata;
  logic [63:0] last_ls_rdata;
  logic        last_ls_err;
  vec_t tbl [13];

  ram_arb_bridge_if #(.IDX_W(16)) bus ();

  ram_arb_bridge #(.BASE_ADDR(BASE), .IDX_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.ram_rdata_i = mem[bus.ram_idx_o];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock; RAM write strobes are sampled just before the edge.
  task automatic tick();
    logic        we;
    logic [15:0] ix;
    logic [63:0] wd, wm;
    we = bus.ram_en_o && bus.ram_wen_o;
    ix = bus.ram_idx_o;
    wd = bus.ram_wdata_o;
    wm = bus.ram_wmask_o;
    @(posedge clock);
    #1;
    if (we) mem[ix] = (mem[ix] & ~wm) | (wd & wm);
  endtask

  task automatic idle_inputs();
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = 64'd0;
    bus.ls_req_i   = 1'b0;
    bus.ls_wen_i   = 1'b0;
    bus.ls_addr_i  = 64'd0;
    bus.ls_wdata_i = 64'd0;
    bus.ls_size_i  = 3'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ram_en"},   {63'd0, bus.ram_en_o},   64'd0);
    chk({tag, "_ram_wen"},  {63'd0, bus.ram_wen_o},  64'd0);
    chk({tag, "_ram_idx"},  {48'd0, bus.ram_idx_o},  64'd0);
    chk({tag, "_ram_wdata"}, bus.ram_wdata_o,        64'd0);
    chk({tag, "_ram_wmask"}, bus.ram_wmask_o,        64'd0);
    chk({tag, "_if_ready"}, {63'd0, bus.if_ready_o}, 64'd0);
    chk({tag, "_if_rdata"}, {32'd0, bus.if_rdata_o}, 64'd0);
    chk({tag, "_ls_ready"}, {63'd0, bus.ls_ready_o}, 64'd0);
    chk({tag, "_ls_rdata"}, bus.ls_rdata_o,          64'd0);
    chk({tag, "_ls_err"},   {63'd0, bus.ls_err_o},   64'd0);
    last_if_rdata = 32'd0;
    last_ls_rdata = 64'd0;
    last_ls_err   = 1'b0;
  endtask

  // Reference behaviour of one transaction, derived from address arithmetic.
  task automatic model_txn(input bit is_ls, input bit wen, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [2:0] size, output exp_t e);
    logic [63:0] diff, old;
    logic [15:0] ix;
    int off, nbytes;
    diff   = addr - BASE;
    off    = int'(addr % 64'd8);
    nbytes = 1 << size;
    e      = '0;
    e.err  = is_ls && ((size > 3'd3) || (off + nbytes > 8) || (addr < BASE) || ((diff / 64'd8) >= 64'd65536));
    e.en   = !e.err;
    e.wen  = is_ls && wen && !e.err;
    ix     = 16'(diff / 64'd8);
    e.idx  = ix;
    old    = ref_mem[ix];
    if (is_ls) e.rdata = e.err ? 64'd0 : (old >> (off * 8));
    else       e.rdata = ((addr % 64'd8) >= 64'd4) ? (old >> 32) : (old & 64'h0000_0000_FFFF_FFFF);
    if (e.wen) begin
      e.wdata = wdata << (off * 8);
      for (int b = 0; b < 8; b++) begin
        if (b >= off && b < off + nbytes) begin
          e.wmask[b*8 +: 8]    = 8'hFF;
          ref_mem[ix][b*8 +: 8] = wdata[(b - off)*8 +: 8];
        end
      end
    end
  endtask

  // Issue one request from IDLE and check ACCESS, RESP and the following IDLE.
  task automatic run_txn(input bit is_ls, input bit wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [2:0] size, input exp_t e);
    idle_inputs();
    if (is_ls) begin
      bus.ls_req_i = 1'b1; bus.ls_wen_i = wen; bus.ls_addr_i = addr;
      bus.ls_wdata_i = wdata; bus.ls_size_i = size;
    end else begin
      bus.if_req_i = 1'b1; bus.if_addr_i = addr;
    end
    tick();
    // Garbage on the inputs must not disturb the request already latched.
    bus.if_req_i   = 1'b0;
    bus.ls_req_i   = 1'b0;
    bus.if_addr_i  = {$urandom, $urandom};
    bus.ls_addr_i  = {$urandom, $urandom};
    bus.ls_wdata_i = {$urandom, $urandom};
    bus.ls_size_i  = 3'($urandom);
    bus.ls_wen_i   = 1'($urandom);
    chk("access_ram_en",  {63'd0, bus.ram_en_o},  {63'd0, e.en});
    chk("access_ram_wen", {63'd0, bus.ram_wen_o}, {63'd0, e.wen});
    if (e.en) chk("access_ram_idx", {48'd0, bus.ram_idx_o}, {48'd0, e.idx});
    if (e.wen) begin
      chk("access_ram_wdata", bus.ram_wdata_o, e.wdata);
      chk("access_ram_wmask", bus.ram_wmask_o, e.wmask);
    end
    chk("access_no_ready", {62'd0, bus.if_ready_o, bus.ls_ready_o}, 64'd0);
    tick();
    if (is_ls) begin
      chk("resp_ready", {62'd0, bus.if_ready_o, bus.ls_ready_o}, 64'd1);
      chk("resp_ls_rdata", bus.ls_rdata_o, e.rdata);
      chk("resp_ls_err", {63'd0, bus.ls_err_o}, {63'd0, e.err});
      chk("hold_if_rdata", {32'd0, bus.if_rdata_o}, {32'd0, last_if_rdata});
      last_ls_rdata = e.rdata;
      last_ls_err   = e.err;
    end else begin
      chk("resp_ready", {62'd0, bus.if_ready_o, bus.ls_ready_o}, 64'd2);
      chk("resp_if_rdata", {32'd0, bus.if_rdata_o}, {32'd0, e.rdata[31:0]});
      chk("hold_ls_rdata", bus.ls_rdata_o, last_ls_rdata);
      chk("hold_ls_err", {63'd0, bus.ls_err_o}, {63'd0, last_ls_err});
      last_if_rdata = e.rdata[31:0];
    end
    tick();
    chk("idle_no_ready", {62'd0, bus.if_ready_o, bus.ls_ready_o}, 64'd0);
  endtask

  // Both ports request together: IF must win right after reset, then LS.
  task automatic tie_test(input string tag);
    logic [63:0] exp_if, exp_ls;
    exp_if = ref_mem[0] >> 32;
    exp_ls = ref_mem[1];
    idle_inputs();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = BASE + 64'd4;
    bus.ls_req_i  = 1'b1;
    bus.ls_addr_i = BASE + 64'd8;
    bus.ls_size_i = 3'd3;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk({tag, "_if_ready"}, {63'd0, bus.if_ready_o}, {63'd0, (c == 2)});
      chk({tag, "_ls_ready"}, {63'd0, bus.ls_ready_o}, {63'd0, (c == 5)});
      if (c == 2) chk({tag, "_if_rdata"}, {32'd0, bus.if_rdata_o}, exp_if);
      if (c == 5) chk({tag, "_ls_rdata"}, bus.ls_rdata_o, exp_ls);
      if (c == 4) idle_inputs();
    end
    last_if_rdata = exp_if[31:0];
    last_ls_rdata = exp_ls;
    last_ls_err   = 1'b0;
  endtask

  function automatic vec_t row(bit is_ls, bit wen, logic [63:0] addr, logic [63:0] wdata,
                               logic [2:0] size, bit en, bit wen_e, logic [15:0] idx,
                               logic [63:0] wd_e, logic [63:0] wm_e, bit err, logic [63:0] rd_e);
    vec_t v;
    v.is_ls = is_ls; v.wen = wen; v.addr = addr; v.wdata = wdata; v.size = size;
    v.e.en = en; v.e.wen = wen_e; v.e.idx = idx; v.e.wdata = wd_e; v.e.wmask = wm_e;
    v.e.err = err; v.e.rdata = rd_e;
    return v;
  endfunction

  initial begin
    exp_t        e;
    bit          is_ls, wen;
    logic [63:0] addr, wdata;
    logic [2:0]  size;
    int          r;

    pass_cnt  = 0;
    total_cnt = 0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = {16'hC0DE, i[15:0], 16'h5EED, ~i[15:0]};
    end
    mem[0]     = 64'h1111_2222_3333_4444;
    mem[1]     = 64'hDEAD_BEEF_0BAD_F00D;
    mem[2]     = 64'h0123_4567_89AB_CDEF;
    mem[65535] = 64'hFEED_FACE_CAFE_BEEF;
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];

    idle_inputs();
    reset = 1'b1;
    tick(); tick(); tick();
    check_reset_outputs("por");
    reset = 1'b0;

    tie_test("tie0");

    tbl[0]  = row(1'b0, 1'b0, 64'h8000_0004, 64'd0,  3'd0, 1'b1, 1'b0, 16'h0000, 64'd0, 64'd0, 1'b0, 64'h0000_0000_1111_2222);
    tbl[1]  = row(1'b0, 1'b0, 64'h8000_0000, 64'd0,  3'd0, 1'b1, 1'b0, 16'h0000, 64'd0, 64'd0, 1'b0, 64'h0000_0000_3333_4444);
    tbl[2]  = row(1'b1, 1'b1, 64'h8000_0013, 64'hAB, 3'd0, 1'b1, 1'b1, 16'h0002, 64'h0000_0000_AB00_0000, 64'h0000_0000_FF00_0000, 1'b0, 64'h0000_0001_2345_6789);
    tbl[3]  = row(1'b1, 1'b0, 64'h8000_0010, 64'd0,  3'd3, 1'b1, 1'b0, 16'h0002, 64'd0, 64'd0, 1'b0, 64'h0123_4567_ABAB_CDEF);
    tbl[4]  = row(1'b1, 1'b0, 64'h8000_0006, 64'd0,  3'd2, 1'b0, 1'b0, 16'h0000, 64'd0, 64'd0, 1'b1, 64'd0);
    tbl[5]  = row(1'b1, 1'b0, 64'h8000_0002, 64'd0,  3'd1, 1'b1, 1'b0, 16'h0000, 64'd0, 64'd0, 1'b0, 64'h0000_1111_2222_3333);
    tbl[6]  = row(1'b1, 1'b0, 64'h7FFF_FFF8, 64'd0,  3'd3, 1'b0, 1'b0, 16'h0000, 64'd0, 64'd0, 1'b1, 64'd0);
    tbl[7]  = row(1'b1, 1'b0, 64'h8007_FFF8, 64'd0,  3'd3, 1'b1, 1'b0, 16'hFFFF, 64'd0, 64'd0, 1'b0, 64'hFEED_FACE_CAFE_BEEF);
    tbl[8]  = row(1'b1, 1'b0, 64'h8000_0000, 64'd0,  3'd4, 1'b0, 1'b0, 16'h0000, 64'd0, 64'd0, 1'b1, 64'd0);
    tbl[9]  = row(1'b1, 1'b0, 64'h8008_0000, 64'd0,  3'd0, 1'b0, 1'b0, 16'h0000, 64'd0, 64'd0, 1'b1, 64'd0);
    tbl[10] = row(1'b1, 1'b1, 64'h8000_0016, 64'h1234, 3'd1, 1'b1, 1'b1, 16'h0002, 64'h1234_0000_0000_0000, 64'hFFFF_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0123);
    tbl[11] = row(1'b1, 1'b1, 64'h8000_0011, 64'h55, 3'd3, 1'b0, 1'b0, 16'h0000, 64'd0, 64'd0, 1'b1, 64'd0);
    tbl[12] = row(1'b0, 1'b0, 64'h8000_0014, 64'd0,  3'd0, 1'b1, 1'b0, 16'h0002, 64'd0, 64'd0, 1'b0, 64'h0000_0000_1234_4567);
    for (int i = 0; i < 13; i++) begin
      run_txn(tbl[i].is_ls, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].size, tbl[i].e);
    end
    // The directed stores above rewrote bytes of word 2.
    ref_mem[2] = 64'h1234_4567_ABAB_CDEF;

    // An IF grant followed by reset: the next tie must still go to IF.
    model_txn(1'b0, 1'b0, BASE + 64'd8, 64'd0, 3'd0, e);
    run_txn(1'b0, 1'b0, BASE + 64'd8, 64'd0, 3'd0, e);
    reset = 1'b1;
    tick(); tick();
    check_reset_outputs("rst2");
    reset = 1'b0;
    tie_test("tie1");

    // Reset landing in the ACCESS cycle of a store.
    idle_inputs();
    bus.ls_req_i   = 1'b1;
    bus.ls_wen_i   = 1'b1;
    bus.ls_addr_i  = BASE + 64'd32;
    bus.ls_wdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.ls_size_i  = 3'd3;
    tick();
    idle_inputs();
    chk("rsta_wen_before", {63'd0, bus.ram_wen_o}, 64'd1);
    reset = 1'b1;
    #1;
    chk("rsta_wen_gated", {63'd0, bus.ram_wen_o}, 64'd0);
    chk("rsta_en_gated",  {63'd0, bus.ram_en_o},  64'd0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rsta_no_ready", {62'd0, bus.if_ready_o, bus.ls_ready_o}, 64'd0);
      tick();
    end
    last_if_rdata = 32'd0;
    last_ls_rdata = 64'd0;
    last_ls_err   = 1'b0;
    model_txn(1'b1, 1'b0, BASE + 64'd32, 64'd0, 3'd3, e);
    run_txn(1'b1, 1'b0, BASE + 64'd32, 64'd0, 3'd3, e);

    // Randomized traffic against the byte-level reference RAM.
    for (int n = 0; n < 200; n++) begin
      is_ls = 1'($urandom_range(0, 1));
      wen   = 1'($urandom_range(0, 1));
      wdata = {$urandom, $urandom};
      size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      r     = int'($urandom_range(0, 9));
      if (!is_ls) begin
        addr = (r < 2) ? (BASE + 64'h7_FFC0 + 64'($urandom_range(0, 63)))
                       : (BASE + 64'($urandom_range(0, 511)));
      end else if (r == 0) begin
        addr = BASE - 64'($urandom_range(1, 64));
      end else if (r == 1) begin
        addr = BASE + 64'h8_0000 + 64'($urandom_range(0, 63));
      end else if (r == 2) begin
        addr = BASE + 64'h7_FFC0 + 64'($urandom_range(0, 63));
      end else begin
        addr = BASE + 64'($urandom_range(0, 511));
      end
      model_txn(is_ls, wen, addr, wdata, size, e);
      run_txn(is_ls, wen, addr, wdata, size, e);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ram_arb_bridge.md
RAM_ARB_BRIDGE -- requirements
Module: ram_arb_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h0000_0000_8000_0000, physical address of RAM index 0.
REQ-002 SHALL have parameter IDX_W, default 16, RAM index width; RAM spans 2^IDX_W 64-bit words.
REQ-003 clock  in  1  clock; all state on posedge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 if_req_i  in  1  instruction fetch request.
REQ-006 if_addr_i  in  64  fetch byte address.
REQ-007 if_ready_o  out  1  fetch response strobe, one cycle.
REQ-008 if_rdata_o  out  32  instruction word selected by addr[2].
REQ-009 ls_req_i  in  1  load/store request.
REQ-010 ls_wen_i  in  1  1 = store, 0 = load.
REQ-011 ls_addr_i  in  64  load/store byte address.
REQ-012 ls_wdata_i  in  64  store data, LSB-aligned.
REQ-013 ls_size_i  in  3  log2 bytes, 0..3; 4..7 illegal.
REQ-014 ls_ready_o  out  1  load/store response strobe, one cycle.
REQ-015 ls_rdata_o  out  64  load word shifted right by addr[2:0]*8, zero-filled.
REQ-016 ls_err_o  out  1  error flag, valid with ls_ready_o.
REQ-017 ram_en_o  out  1  RAM access enable.
REQ-018 ram_idx_o  out  IDX_W  word index, shared by read and write.
REQ-019 ram_wen_o  out  1  RAM write enable.
REQ-020 ram_wdata_o  out  64  write data, lane-shifted.
REQ-021 ram_wmask_o  out  64  bit-granular write mask.
REQ-022 ram_rdata_i  in  64  RAM read data, valid in the cycle ram_en_o is high.

Function
REQ-023 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on any pending req; ACCESS->RESP always; RESP->IDLE always.
REQ-024 In IDLE, grant, wen, addr, wdata and size SHALL be latched; later input changes are ignored until RESP completes.
REQ-025 Arbitration round-robin: on simultaneous requests, grant the port not granted last; last_grant resets to LS, so IF wins the first tie.
REQ-026 Single requester is granted immediately regardless of last_grant.
REQ-027 ram_en_o high only in ACCESS; ram_idx_o = (addr - BASE_ADDR) >> 3, truncated to IDX_W.
REQ-028 ram_rdata_i SHALL be captured at the end of ACCESS; ready strobe and data are driven in RESP, 2 cycles after the request edge.
REQ-029 Store: ram_wen_o = 1 in ACCESS; ram_wdata_o = wdata << (addr[2:0]*8); ram_wmask_o = byte mask of 2^size bytes at offset addr[2:0], each byte expanded to 8 bits.
REQ-030 LS error if addr[2:0] + 2^size > 8, size > 3, addr < BASE_ADDR, or (addr - BASE_ADDR) >> 3 >= 2^IDX_W.
REQ-031 On LS error, ram_en_o and ram_wen_o stay 0, and ls_rdata_o = 0 and ls_err_o = 1 with ls_ready_o.
REQ-032 IF requests are never checked for errors; if_rdata_o = addr[2] ? rdata[63:32] : rdata[31:0].
REQ-033 A new request may be asserted in the RESP cycle; it is sampled in the following IDLE cycle, giving a minimum 3-cycle issue interval.
REQ-034 if_ready_o and ls_ready_o are never high together; a port's rdata and err hold their value until that port's next ready.

Reset
REQ-035 On reset: state IDLE, last_grant LS; all outputs 0, including rdata, err and masks.
REQ-036 Reset during ACCESS SHALL suppress the RAM write in that cycle (ram_en_o and ram_wen_o gated by ~reset); the pending request is discarded with no ready.

Structure
REQ-037 FSM state encoding, the size encoding, and BASE_ADDR default SHALL live in the shared defines package (BASE_ADDR equals the existing PC_START).
REQ-038 One sub-module, ram_lane_align: combinational wdata/wmask shift and rdata extract from addr[2:0] and size.

Verification
REQ-039 IF req addr 0x8000_0004, RAM word 0x1111_2222_3333_4444 -> ram_idx 0, if_ready at +2, if_rdata 0x1111_2222.
REQ-040 LS store size 0 addr 0x8000_0013 wdata 0xAB -> ram_idx 2, ram_wdata byte3 = 0xAB, ram_wmask 64'h0000_0000_FF00_0000.
REQ-041 IF and LS asserted together, held for 2 transactions -> IF served first, then LS; no overlapping ready.
REQ-042 LS load size 2 addr 0x8000_0006 -> no RAM enable, ls_ready with ls_err 1, ls_rdata 0.
REQ-043 Reset asserted in the ACCESS cycle of a store -> ram_wen_o 0 in that cycle, no ready, state IDLE afterwards.
REQ-044 LS load addr 0x7FFF_FFF8 -> ls_err 1; load addr 0x8007_FFF8 -> ram_idx 0xFFFF, no error.
